aes_block_packer: RTL and testbench
===================================

# aes_block_packer

Byte-stream front end for the AES encryption engine. It packs an 8-bit byte stream into 128-bit plaintext blocks and presents them to the engine's block input (`blok`/`g_gecerli`, gated by the engine's `hazir`). A two-register design (assembly plus output) lets the next block be collected while the previous one waits for the engine. Optional PKCS#7 padding closes out each message.

## Interface
Parameters:
- none (block width 128, byte width 8, fixed)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; rst, synchronous, active-high; clock clk
- `bayt_i`  in  8  input byte
- `bayt_gecerli_i`  in  1  `bayt_i` valid
- `son_i`  in  1  last byte of message; qualified by a byte transfer
- `bayt_hazir_o`  out  1  packer can accept a byte
- `blok_o`  out  128  plaintext block to engine `blok`
- `g_gecerli_o`  out  1  `blok_o` valid; drives engine `g_gecerli`
- `hazir_i`  in  1  engine `hazir`
- `blok_son_o`  out  1  current `blok_o` is the final block of a message
- `blok_sayac_o`  out  16  blocks accepted by the engine in the current message

## Operation
- **Byte transfer:** `bayt_gecerli_i && bayt_hazir_o` in the same cycle.
- **Block transfer:** `g_gecerli_o && hazir_i` in the same cycle.
- **Byte order:** the k-th byte of a block (k=0..15) goes to `asm[127-8k -: 8]`. The first byte lands in `[127:120]` (FIPS-197 order).
- **Assembly register `asm`, byte count `cnt` (0..15):**
  - Each byte transfer writes `asm` and increments `cnt`.
  - A block is complete on the 16th byte, or on any byte with `son_i=1`.
- **Padding without the macro:** on a partial final block, unfilled bytes are 0x00.
- **Completed-block handling:**
  - The block moves to the output register `out` if `out` is empty or is being drained in that same cycle.
  - Otherwise `asm` holds it and `bayt_hazir_o=0` until `out` frees.
  - `blok_son_o` is loaded with the block's last flag.
- **States:**
  - `COLLECT`: normal byte collection.
  - `HOLD`: `asm` full, waiting for `out`.
  - `PAD`: macro only; a pad-only block is pending.
- **Transitions:**
  - `COLLECT` to `HOLD` when a block completes and cannot be transferred.
  - `HOLD` to `COLLECT` on transfer into `out`.
  - `PAD` to `COLLECT` once the pad block has been loaded into `out`.
- **`bayt_hazir_o`:** 1 only in `COLLECT` and not in reset.
- **`blok_sayac_o`:**
  - Increments on each block transfer; wraps from 0xFFFF to 0x0000.
  - Clears to 0 the cycle after the transfer of a block with `blok_son_o=1`.
- **Simultaneous events:** a drain of `out` and a load of a new block in the same cycle gives no bubble, and `g_gecerli_o` stays 1.
- **`out` contents:** `blok_o` and `blok_son_o` are stable while `g_gecerli_o=1` and `hazir_i=0`.

## Timing
- **Reset values:** `bayt_hazir_o=0` while `rst=1`. `g_gecerli_o=0`, `blok_o=0`, `blok_son_o=0`, `blok_sayac_o=0`, `cnt=0`, state `COLLECT`.
- **Ready after reset:** `bayt_hazir_o=1` from the first cycle with `rst=0`.
- **Latency:** a byte completing a block at cycle t gives `g_gecerli_o=1` at t+1, provided `out` is free.
- **Reset mid-operation:** any partial block and any pending `out` are discarded. Nothing is emitted after reset.
- **Throughput:** 1 byte/cycle sustained. Up to 32 bytes are buffered before backpressure.
- **Idle `hazir_i`:** `hazir_i` ignored when `g_gecerli_o=0`.

## Configuration
- **`AES_PKCS7_PAD_EN` defined:**
  - A final block holding k<16 message bytes has its remaining 16-k bytes set to the value 16-k.
  - If the final byte fills the block (k=16), that block leaves with `blok_son_o=0`. The FSM then enters `PAD` and emits an extra block of sixteen 0x10 bytes with `blok_son_o=1`.
  - `bayt_hazir_o=0` while in `PAD`.
- **Undefined:** zero fill, no `PAD` state; the block carrying `son_i` has `blok_son_o=1`.

## Test plan
- **Full block:** bytes 0x00..0x0F, `son_i=0`, `hazir_i=1`. Expect `blok_o=000102...0F` and `g_gecerli_o` for 1 cycle at t+1. `blok_sayac_o` goes to 1.
- **Short message, no macro:** bytes 0xA1..0xA5, `son_i` on the 5th. Expect `blok_o=A1A2A3A4A5` followed by 22 hex zeros, `blok_son_o=1`, and `blok_sayac_o` returning to 0 after the transfer.
- **Short message, `AES_PKCS7_PAD_EN`:** same stimulus. Expect `blok_o=A1A2A3A4A5` followed by eleven 0x0B bytes, `blok_son_o=1`.
- **Full final block, `AES_PKCS7_PAD_EN`:** 16 bytes 0xFF, `son_i` on the 16th. Expect two blocks: all-FF (`blok_son_o=0`), then all-0x10 (`blok_son_o=1`).
- **Backpressure:** `hazir_i=0` for 50 cycles while streaming 48 bytes. Expect `bayt_hazir_o=0` after 32 bytes accepted, `blok_o` stable. On `hazir_i=1`, three blocks emerge in order, with no loss or duplication.
- **Reset mid-block:** assert `rst` after 7 bytes, then send 16 new bytes. Expect only one block, containing the new bytes, and `blok_sayac_o=1`.

Source files
------------

// File: rtl/aes_block_packer.sv
// Packs an 8-bit byte stream into 128-bit AES plaintext blocks (first byte in [127:120]).
// Define AES_PKCS7_PAD_EN for PKCS#7 padding of the final block; default is zero fill.
module aes_block_packer (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   bayt_i,
    input  logic         bayt_gecerli_i,
    input  logic         son_i,
    output logic         bayt_hazir_o,
    output logic [127:0] blok_o,
    output logic         g_gecerli_o,
    input  logic         hazir_i,
    output logic         blok_son_o,
    output logic [15:0]  blok_sayac_o
);

`ifdef AES_PKCS7_PAD_EN
    typedef enum logic [1:0] {COLLECT, HOLD, PAD} state_e;
`else
    typedef enum logic [1:0] {COLLECT, HOLD} state_e;
`endif

    state_e        state_q, state_d;
    logic [127:0]  asm_q, asm_d;
    logic [127:0]  out_q, out_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          asm_son_q, asm_son_d;
    logic          out_vld_q, out_vld_d;
    logic          out_son_q, out_son_d;
    logic [15:0]   sayac_q, sayac_d;
`ifdef AES_PKCS7_PAD_EN
    logic          pad_pend_q, pad_pend_d;
    logic          need_pad;
`endif

    logic          byte_xfer;
    logic          drain;
    logic          out_free;
    logic          blk_done;
    logic          last_flag;
    logic [7:0]    fill;
    logic [127:0]  merged;

    assign bayt_hazir_o = (state_q == COLLECT) && !rst;
    assign g_gecerli_o  = out_vld_q;
    assign blok_o       = out_q;
    assign blok_son_o   = out_son_q;
    assign blok_sayac_o = sayac_q;

    always_comb begin
        byte_xfer = bayt_gecerli_i && bayt_hazir_o;
        drain     = out_vld_q && hazir_i;
        out_free  = !out_vld_q || drain;
        blk_done  = (cnt_q == 4'hF) || son_i;
`ifdef AES_PKCS7_PAD_EN
        // A final block that is already full carries no padding; a pad-only block follows it.
        fill      = {4'h0, 4'hF - cnt_q};
        need_pad  = son_i && (cnt_q == 4'hF);
        last_flag = son_i && (cnt_q != 4'hF);
`else
        fill      = '0;
        last_flag = son_i;
`endif
        merged = asm_q;
        for (int unsigned i = 0; i < 16; i++) begin
            if (4'(i) == cnt_q)
                merged[127-8*i -: 8] = bayt_i;
            else if (blk_done && (4'(i) > cnt_q))
                merged[127-8*i -: 8] = fill;
        end
    end

    always_comb begin
        state_d   = state_q;
        asm_d     = asm_q;
        cnt_d     = cnt_q;
        asm_son_d = asm_son_q;
        out_d     = out_q;
        out_son_d = out_son_q;
        out_vld_d = out_vld_q && !drain;
        sayac_d   = sayac_q;
`ifdef AES_PKCS7_PAD_EN
        pad_pend_d = pad_pend_q;
`endif
        if (drain)
            sayac_d = out_son_q ? '0 : sayac_q + 16'd1;

        case (state_q)
            COLLECT: begin
                if (byte_xfer) begin
                    if (!blk_done) begin
                        asm_d = merged;
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        cnt_d = '0;
                        if (out_free) begin
                            out_d     = merged;
                            out_son_d = last_flag;
                            out_vld_d = 1'b1;
`ifdef AES_PKCS7_PAD_EN
                            if (need_pad)
                                state_d = PAD;
`endif
                        end else begin
                            asm_d     = merged;
                            asm_son_d = last_flag;
                            state_d   = HOLD;
`ifdef AES_PKCS7_PAD_EN
                            pad_pend_d = need_pad;
`endif
                        end
                    end
                end
            end
            HOLD: begin
                if (out_free) begin
                    out_d     = asm_q;
                    out_son_d = asm_son_q;
                    out_vld_d = 1'b1;
                    state_d   = COLLECT;
`ifdef AES_PKCS7_PAD_EN
                    if (pad_pend_q) begin
                        state_d    = PAD;
                        pad_pend_d = 1'b0;
                    end
`endif
                end
            end
`ifdef AES_PKCS7_PAD_EN
            PAD: begin
                if (out_free) begin
                    out_d     = {16{8'h10}};
                    out_son_d = 1'b1;
                    out_vld_d = 1'b1;
                    state_d   = COLLECT;
                end
            end
`endif
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COLLECT;
            asm_q     <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
            asm_son_q <= 1'b0;
            out_vld_q <= 1'b0;
            out_son_q <= 1'b0;
            sayac_q   <= '0;
`ifdef AES_PKCS7_PAD_EN
            pad_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            asm_q     <= asm_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            asm_son_q <= asm_son_d;
            out_vld_q <= out_vld_d;
            out_son_q <= out_son_d;
            sayac_q   <= sayac_d;
`ifdef AES_PKCS7_PAD_EN
            pad_pend_q <= pad_pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed bench for aes_block_packer: cycle table for basic blocks plus sequences for
// padding, backpressure and mid-block reset. Expectations follow AES_PKCS7_PAD_EN.
module tb_aes_block_packer;

    logic         clk;
    logic         rst;
    logic [7:0]   bayt_i;
    logic         bayt_gecerli_i;
    logic         son_i;
    logic         bayt_hazir_o;
    logic [127:0] blok_o;
    logic         g_gecerli_o;
    logic         hazir_i;
    logic         blok_son_o;
    logic [15:0]  blok_sayac_o;

    aes_block_packer dut (
        .clk            (clk),
        .rst            (rst),
        .bayt_i         (bayt_i),
        .bayt_gecerli_i (bayt_gecerli_i),
        .son_i          (son_i),
        .bayt_hazir_o   (bayt_hazir_o),
        .blok_o         (blok_o),
        .g_gecerli_o    (g_gecerli_o),
        .hazir_i        (hazir_i),
        .blok_son_o     (blok_son_o),
        .blok_sayac_o   (blok_sayac_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [127:0] q_blk[$];
    logic         q_son[$];

    // Every block transfer seen by the engine, in order.
    always @(negedge clk) begin
        if (!rst && g_gecerli_o && hazir_i) begin
            q_blk.push_back(blok_o);
            q_son.push_back(blok_son_o);
        end
    end

    typedef struct {
        logic [7:0]   b;
        logic         v;
        logic         s;
        logic         h;
        logic         exp_gv;
        logic [15:0]  exp_cnt;
        logic         chk_blk;
        logic         exp_son;
        logic [127:0] exp_blk;
    } vec_t;

    vec_t vt[25];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc(output bit acc);
        @(negedge clk);
        acc = bayt_gecerli_i && bayt_hazir_o;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cyc(acc);
    endtask

    task automatic send(input logic [7:0] base, input bit inc, input int n,
                        input bit son_last, input int max_cyc);
        int sent;
        bit acc;
        sent = 0;
        for (int c = 0; c < max_cyc && sent < n; c++) begin
            bayt_i         = inc ? base + 8'(sent) : base;
            bayt_gecerli_i = 1'b1;
            son_i          = son_last && (sent == n - 1);
            cyc(acc);
            if (acc) sent++;
        end
        bayt_gecerli_i = 1'b0;
        son_i          = 1'b0;
        chk("send_count", 128'(sent), 128'(n));
    endtask

    function automatic logic [127:0] mk(input logic [7:0] base);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = base + 8'(k);
        return r;
    endfunction

    function automatic logic [127:0] qb(input int i);
        return (q_blk.size() > i) ? q_blk[i] : 'x;
    endfunction

    function automatic logic qs(input int i);
        return (q_son.size() > i) ? q_son[i] : 1'bx;
    endfunction

    logic [127:0] short_exp;
    logic [127:0] held;
    bit           unstable;
    bit           seen_gv;
    bit           acc;
    int           sent;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
`ifdef AES_PKCS7_PAD_EN
        short_exp = {40'hA1A2A3A4A5, {11{8'h0B}}};
`else
        short_exp = {40'hA1A2A3A4A5, 88'h0};
`endif
        // Vectors 0..15: full block, 16..17: drain/idle, 18..22: short final message, 23..24: drain/idle.
        for (int i = 0; i < 25; i++) begin
            vt[i] = '{b: 8'h00, v: 1'b0, s: 1'b0, h: 1'b1, exp_gv: 1'b0, exp_cnt: 16'd0,
                      chk_blk: 1'b0, exp_son: 1'b0, exp_blk: '0};
        end
        for (int i = 0; i < 16; i++) begin
            vt[i].b = 8'(i);
            vt[i].v = 1'b1;
        end
        vt[15].exp_gv  = 1'b1;
        vt[15].chk_blk = 1'b1;
        vt[15].exp_blk = 128'h000102030405060708090A0B0C0D0E0F;
        vt[16].exp_cnt = 16'd1;
        vt[17].exp_cnt = 16'd1;
        for (int i = 18; i < 23; i++) begin
            vt[i].b       = 8'hA1 + 8'(i - 18);
            vt[i].v       = 1'b1;
            vt[i].exp_cnt = 16'd1;
        end
        vt[22].s       = 1'b1;
        vt[22].exp_gv  = 1'b1;
        vt[22].chk_blk = 1'b1;
        vt[22].exp_son = 1'b1;
        vt[22].exp_blk = short_exp;

        rst = 1'b1; bayt_i = '0; bayt_gecerli_i = 1'b0; son_i = 1'b0; hazir_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bayt_hazir", 128'(bayt_hazir_o), 128'd0);
        chk("rst_g_gecerli", 128'(g_gecerli_o), 128'd0);
        chk("rst_blok", blok_o, 128'd0);
        chk("rst_blok_son", 128'(blok_son_o), 128'd0);
        chk("rst_sayac", 128'(blok_sayac_o), 128'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 128'(bayt_hazir_o), 128'd1);

        for (int i = 0; i < 25; i++) begin
            bayt_i = vt[i].b; bayt_gecerli_i = vt[i].v; son_i = vt[i].s; hazir_i = vt[i].h;
            cyc(acc);
            chk($sformatf("vec%0d_gv", i), 128'(g_gecerli_o), 128'(vt[i].exp_gv));
            chk($sformatf("vec%0d_hazir", i), 128'(bayt_hazir_o), 128'd1);
            chk($sformatf("vec%0d_sayac", i), 128'(blok_sayac_o), 128'(vt[i].exp_cnt));
            if (vt[i].chk_blk) begin
                chk($sformatf("vec%0d_blok", i), blok_o, vt[i].exp_blk);
                chk($sformatf("vec%0d_son", i), 128'(blok_son_o), 128'(vt[i].exp_son));
            end
        end
        bayt_gecerli_i = 1'b0; son_i = 1'b0;

        // Final block that is exactly full.
        q_blk.delete(); q_son.delete();
        hazir_i = 1'b1;
        send(8'hFF, 1'b0, 16, 1'b1, 40);
        idle(5);
`ifdef AES_PKCS7_PAD_EN
        chk("full_final_nblk", 128'(q_blk.size()), 128'd2);
        chk("full_final_blk0", qb(0), {128{1'b1}});
        chk("full_final_son0", 128'(qs(0)), 128'd0);
        chk("full_final_blk1", qb(1), {16{8'h10}});
        chk("full_final_son1", 128'(qs(1)), 128'd1);
`else
        chk("full_final_nblk", 128'(q_blk.size()), 128'd1);
        chk("full_final_blk0", qb(0), {128{1'b1}});
        chk("full_final_son0", 128'(qs(0)), 128'd1);
`endif
        chk("full_final_sayac", 128'(blok_sayac_o), 128'd0);

        // Backpressure: 48 bytes offered while the engine stalls for 50 cycles.
        q_blk.delete(); q_son.delete();
        hazir_i = 1'b0; sent = 0; unstable = 1'b0; seen_gv = 1'b0; held = '0;
        for (int c = 0; c < 50; c++) begin
            bayt_i = 8'h20 + 8'(sent); bayt_gecerli_i = (sent < 48);
            cyc(acc);
            if (acc) sent++;
            if (g_gecerli_o) begin
                if (!seen_gv) held = blok_o;
                else if (blok_o !== held) unstable = 1'b1;
                seen_gv = 1'b1;
            end
        end
        chk("bp_accepted", 128'(sent), 128'd32);
        chk("bp_bayt_hazir", 128'(bayt_hazir_o), 128'd0);
        chk("bp_g_gecerli", 128'(g_gecerli_o), 128'd1);
        chk("bp_blok_first", blok_o, mk(8'h20));
        chk("bp_stable", 128'(unstable), 128'd0);
        chk("bp_no_transfer", 128'(q_blk.size()), 128'd0);
        hazir_i = 1'b1;
        bayt_i = 8'h20 + 8'(sent); bayt_gecerli_i = 1'b1;
        cyc(acc);
        if (acc) sent++;
        chk("bp_no_bubble_gv", 128'(g_gecerli_o), 128'd1);
        chk("bp_no_bubble_blok", blok_o, mk(8'h30));
        for (int c = 0; c < 100 && (sent < 48 || q_blk.size() < 3); c++) begin
            bayt_i = 8'h20 + 8'(sent); bayt_gecerli_i = (sent < 48);
            cyc(acc);
            if (acc) sent++;
        end
        bayt_gecerli_i = 1'b0;
        idle(3);
        chk("bp_nblk", 128'(q_blk.size()), 128'd3);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("bp_blk%0d", j), qb(j), mk(8'h20 + 8'(16 * j)));
            chk($sformatf("bp_son%0d", j), 128'(qs(j)), 128'd0);
        end
        chk("bp_sayac", 128'(blok_sayac_o), 128'd3);

        // Reset in the middle of a block.
        send(8'h50, 1'b1, 7, 1'b0, 20);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        q_blk.delete(); q_son.delete();
        chk("mid_rst_gv", 128'(g_gecerli_o), 128'd0);
        chk("mid_rst_sayac", 128'(blok_sayac_o), 128'd0);
        idle(3);
        chk("mid_rst_nothing", 128'(q_blk.size()), 128'd0);
        send(8'h60, 1'b1, 16, 1'b0, 40);
        idle(4);
        chk("mid_rst_nblk", 128'(q_blk.size()), 128'd1);
        chk("mid_rst_blk", qb(0), mk(8'h60));
        chk("mid_rst_sayac_after", 128'(blok_sayac_o), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
